// File: rtl/unidad_carga_almacen_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM
// state encoding and the misalignment/illegal-access predicate.
package unidad_carga_almacen_pkg;

    localparam logic [1:0] TAM_BYTE    = 2'b00;
    localparam logic [1:0] TAM_MEDIA   = 2'b01;
    localparam logic [1:0] TAM_PALABRA = 2'b10;
    localparam logic [1:0] TAM_ILEGAL  = 2'b11;

    typedef enum logic [2:0] {
        INACTIVO = 3'd0,
        LEER     = 3'd1,
        LEER_MOD = 3'd2,
        ESCRIBIR = 3'd3,
        FALLO    = 3'd4
    } estado_t;

    // True when the request must be turned away: misaligned half/word or
    // the reserved size code.
    function automatic logic acceso_invalido(input logic [1:0] tamano,
                                             input logic [1:0] desp);
        logic invalido;
        case (tamano)
            TAM_MEDIA:   invalido = desp[0];
            TAM_PALABRA: invalido = (desp != 2'b00);
            TAM_ILEGAL:  invalido = 1'b1;
            default:     invalido = 1'b0;
        endcase
        return invalido;
    endfunction

endpackage

// File: rtl/unidad_carga_almacen_alineador_bytes.sv
// Byte-lane steering for sub-word accesses (purely combinational).
//   palabra        : word read from memory
//   desplazamiento : byte offset inside the word
//   tamano         : access size code
//   con_signo      : sign-extend sub-word loads
//   dato_escritura : right-aligned store data (only the low half is needed)
//   valor_carga    : extracted and extended load value
//   palabra_fusion : palabra with the addressed lane replaced by store data
module alineador_bytes
    import unidad_carga_almacen_pkg::*;
#(
    parameter int ORDEN_GRANDE = 0
) (
    input  logic [31:0] palabra,
    input  logic [1:0]  desplazamiento,
    input  logic [1:0]  tamano,
    input  logic        con_signo,
    input  logic [15:0] dato_escritura,
    output logic [31:0] valor_carga,
    output logic [31:0] palabra_fusion
);

    logic [1:0]  carril_b;
    logic        carril_h;
    logic [7:0]  byte_sel;
    logic [15:0] media_sel;

    always_comb begin
        // Big-endian puts offset 0 in the top lane, so the lane index is
        // the offset mirrored.
        carril_b  = (ORDEN_GRANDE != 0) ? ~desplazamiento    : desplazamiento;
        carril_h  = (ORDEN_GRANDE != 0) ? ~desplazamiento[1] : desplazamiento[1];
        byte_sel  = palabra[{carril_b, 3'b000} +: 8];
        media_sel = palabra[{carril_h, 4'b0000} +: 16];

        case (tamano)
            TAM_BYTE:  valor_carga = {{24{con_signo & byte_sel[7]}}, byte_sel};
            TAM_MEDIA: valor_carga = {{16{con_signo & media_sel[15]}}, media_sel};
            default:   valor_carga = palabra;
        endcase

        palabra_fusion = palabra;
        case (tamano)
            TAM_BYTE:  palabra_fusion[{carril_b, 3'b000} +: 8]  = dato_escritura[7:0];
            TAM_MEDIA: palabra_fusion[{carril_h, 4'b0000} +: 16] = dato_escritura;
            default:   palabra_fusion = palabra;
        endcase
    end

endmodule

// File: rtl/unidad_carga_almacen.sv
// Load/store unit between the MEM-stage control and a word-addressed data
// memory. Sub-word loads are extracted/extended; sub-word stores run as a
// read-modify-write because the memory only writes whole words.
//   clk, rst_n            : clock, asynchronous active-low reset
//   solicitud             : request valid, taken only while ocupado=0
//   es_escritura, tamano, con_signo, direccion_byte, dato_entrada : request
//   ocupado               : access in flight, pipeline stalls
//   listo                 : one-cycle completion pulse
//   dato_salida           : last load result (held)
//   error_alineacion      : one-cycle fault pulse, coincident with listo
//   mem_leer, mem_escribir, mem_direccion, mem_dato_escribir : to memory
//   mem_dato_leer         : combinational read data from memory
module unidad_carga_almacen
    import unidad_carga_almacen_pkg::*;
#(
    parameter int ANCHO_INDICE = 8,
    parameter int ORDEN_GRANDE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        solicitud,
    input  logic        es_escritura,
    input  logic [1:0]  tamano,
    input  logic        con_signo,
    input  logic [31:0] direccion_byte,
    input  logic [31:0] dato_entrada,
    output logic        ocupado,
    output logic        listo,
    output logic [31:0] dato_salida,
    output logic        error_alineacion,
    output logic        mem_leer,
    output logic        mem_escribir,
    output logic [31:0] mem_direccion,
    output logic [31:0] mem_dato_escribir,
    input  logic [31:0] mem_dato_leer
);

    estado_t estado, estado_sig;

    logic [1:0]              tamano_r;
    logic                    con_signo_r;
    logic [1:0]              desp_r;
    logic [ANCHO_INDICE-1:0] indice_r;
    logic [31:0]             dato_r;
    logic [31:0]             fusion_r;

    logic [31:0] valor_carga;
    logic [31:0] palabra_fusion;
    logic [31:0] direccion_palabra;

    // Upper address bits are deliberately ignored (accesses alias).
    logic alias_unused;
    assign alias_unused = ^direccion_byte;

    assign direccion_palabra = {{(32-ANCHO_INDICE){1'b0}}, indice_r};
    assign ocupado           = (estado != INACTIVO);

    alineador_bytes #(.ORDEN_GRANDE(ORDEN_GRANDE)) u_alineador (
        .palabra        (mem_dato_leer),
        .desplazamiento (desp_r),
        .tamano         (tamano_r),
        .con_signo      (con_signo_r),
        .dato_escritura (dato_r[15:0]),
        .valor_carga    (valor_carga),
        .palabra_fusion (palabra_fusion)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= INACTIVO;
        else        estado <= estado_sig;
    end

    // Memory strobes come straight from state, so a reset mid-access can
    // never leave a write strobe behind.
    always_comb begin
        estado_sig        = estado;
        mem_leer          = 1'b0;
        mem_escribir      = 1'b0;
        mem_direccion     = 32'd0;
        mem_dato_escribir = 32'd0;
        case (estado)
            INACTIVO: begin
                if (solicitud) begin
                    if (acceso_invalido(tamano, direccion_byte[1:0])) estado_sig = FALLO;
                    else if (!es_escritura)                           estado_sig = LEER;
                    else if (tamano == TAM_PALABRA)                   estado_sig = ESCRIBIR;
                    else                                              estado_sig = LEER_MOD;
                end
            end
            LEER: begin
                mem_leer      = 1'b1;
                mem_direccion = direccion_palabra;
                estado_sig    = INACTIVO;
            end
            LEER_MOD: begin
                mem_leer      = 1'b1;
                mem_direccion = direccion_palabra;
                estado_sig    = ESCRIBIR;
            end
            ESCRIBIR: begin
                mem_escribir      = 1'b1;
                mem_direccion     = direccion_palabra;
                mem_dato_escribir = (tamano_r == TAM_PALABRA) ? dato_r : fusion_r;
                estado_sig        = INACTIVO;
            end
            FALLO:   estado_sig = INACTIVO;
            default: estado_sig = INACTIVO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tamano_r         <= TAM_BYTE;
            con_signo_r      <= 1'b0;
            desp_r           <= 2'b00;
            indice_r         <= '0;
            dato_r           <= 32'd0;
            fusion_r         <= 32'd0;
            dato_salida      <= 32'd0;
            listo            <= 1'b0;
            error_alineacion <= 1'b0;
        end else begin
            listo            <= 1'b0;
            error_alineacion <= 1'b0;
            if (estado == INACTIVO && solicitud) begin
                tamano_r    <= tamano;
                con_signo_r <= con_signo;
                desp_r      <= direccion_byte[1:0];
                indice_r    <= direccion_byte[ANCHO_INDICE+1:2];
                dato_r      <= dato_entrada;
            end
            case (estado)
                LEER: begin
                    dato_salida <= valor_carga;
                    listo       <= 1'b1;
                end
                LEER_MOD: fusion_r <= palabra_fusion;
                ESCRIBIR: listo <= 1'b1;
                FALLO: begin
                    listo            <= 1'b1;
                    error_alineacion <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
